// File: rtl/cam_subarray_sequencer.sv
// cam_subarray_sequencer
//   Command sequencer sitting directly in front of a CAM subarray. One
//   command is accepted at a time over cmd_valid/cmd_ready. Its fields are
//   registered onto the subarray pins and chip-enable is raised.
//   - Write/update: chip-enable is held until the subarray pulses
//     cam_write_done, then dropped so exactly one write is performed.
//   - Search: the subarray samples on the edge after acceptance, and its
//     tag result is captured one edge later.
//   Every command ends with one response on rsp_valid/rsp_ready.
//
// Ports
//   CLK, rst (async active-low)
//   cmd_*             command channel (valid/ready)
//   rsp_*             response channel (valid/ready): tag, mode, error
//   cam_*             registered drives to the subarray, cam_chip_enable
//   cam_tag_out       subarray search result
//   cam_write_done    subarray write/update complete
//   busy              sequencer not idle
//   op_count          completed non-error commands (wraps)
//
// Optional build macro
//   CAM_SEQ_TIMEOUT_EN: abort a write/update with rsp_error after
//   TIMEOUT_CYCLES cycles in WAIT_WR without cam_write_done. Without the
//   macro, WAIT_WR waits indefinitely.
module cam_subarray_sequencer #(
  parameter int TIMEOUT_CYCLES = 8,
  parameter int CNT_W          = 16
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_mode,
  input  logic             cmd_addr_select,
  input  logic [9:0]       cmd_cmp_addr,
  input  logic [3:0]       cmd_ppg_addr,
  input  logic [1:0]       cmd_cmp_data,
  input  logic [1:0]       cmd_ppg_data,
  input  logic [15:0]      cmd_data,
  input  logic [15:0]      cmd_tag,
  input  logic             cmd_update,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [15:0]      rsp_tag,
  output logic [2:0]       rsp_mode,
  output logic             rsp_error,
  output logic [15:0]      cam_data_in,
  output logic             cam_update_signal,
  output logic [9:0]       cam_cmp_addr,
  output logic [3:0]       cam_ppg_addr,
  output logic [1:0]       cam_cmp_data,
  output logic [1:0]       cam_ppg_data,
  output logic [15:0]      cam_tag_in,
  output logic             cam_addr_select,
  output logic [2:0]       cam_operation_mode,
  output logic             cam_chip_enable,
  input  logic [15:0]      cam_tag_out,
  input  logic             cam_write_done,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [2:0] {IDLE, EXEC, WAIT_WR, CAPTURE, RESP} state_t;

  localparam logic [2:0] MODE_ILLEGAL = 3'b111;

  state_t           state_reg, state_next;
  logic [15:0]      data_reg, data_next;
  logic             upd_reg, upd_next;
  logic [9:0]       cmp_addr_reg, cmp_addr_next;
  logic [3:0]       ppg_addr_reg, ppg_addr_next;
  logic [1:0]       cmp_data_reg, cmp_data_next;
  logic [1:0]       ppg_data_reg, ppg_data_next;
  logic [15:0]      tag_in_reg, tag_in_next;
  logic             addr_sel_reg, addr_sel_next;
  logic [2:0]       mode_reg, mode_next;
  logic             ce_reg, ce_next;
  logic             rsp_valid_reg, rsp_valid_next;
  logic [15:0]      rsp_tag_reg, rsp_tag_next;
  logic [2:0]       rsp_mode_reg, rsp_mode_next;
  logic             rsp_error_reg, rsp_error_next;
  logic [CNT_W-1:0] op_count_reg, op_count_next;

`ifdef CAM_SEQ_TIMEOUT_EN
  localparam int WAIT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
`endif

  // Modes 000 (write) and 001 (update) both complete via cam_write_done.
  logic is_write_mode;
  assign is_write_mode = (mode_reg[2:1] == 2'b00);

  // Gated by rst so the command channel reads not-ready while reset is held.
  assign cmd_ready = rst & (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);

  always_comb begin
    state_next     = state_reg;
    data_next      = data_reg;
    upd_next       = upd_reg;
    cmp_addr_next  = cmp_addr_reg;
    ppg_addr_next  = ppg_addr_reg;
    cmp_data_next  = cmp_data_reg;
    ppg_data_next  = ppg_data_reg;
    tag_in_next    = tag_in_reg;
    addr_sel_next  = addr_sel_reg;
    mode_next      = mode_reg;
    ce_next        = ce_reg;
    rsp_valid_next = rsp_valid_reg;
    rsp_tag_next   = rsp_tag_reg;
    rsp_mode_next  = rsp_mode_reg;
    rsp_error_next = rsp_error_reg;
    op_count_next  = op_count_reg;
`ifdef CAM_SEQ_TIMEOUT_EN
    wait_cnt_next  = wait_cnt_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_mode == MODE_ILLEGAL) begin
            // Rejected without touching the subarray.
            rsp_error_next = 1'b1;
            rsp_tag_next   = '0;
            rsp_mode_next  = cmd_mode;
            rsp_valid_next = 1'b1;
            state_next     = RESP;
          end else begin
            data_next     = cmd_data;
            upd_next      = cmd_update;
            cmp_addr_next = cmd_cmp_addr;
            ppg_addr_next = cmd_ppg_addr;
            cmp_data_next = cmd_cmp_data;
            ppg_data_next = cmd_ppg_data;
            tag_in_next   = cmd_tag;
            addr_sel_next = cmd_addr_select;
            mode_next     = cmd_mode;
            ce_next       = 1'b1;
            state_next    = EXEC;
          end
        end
      end
      EXEC: begin
        if (is_write_mode) begin
          state_next = WAIT_WR;
`ifdef CAM_SEQ_TIMEOUT_EN
          wait_cnt_next = '0;
`endif
        end else begin
          // The subarray samples a search on this edge; release it now.
          ce_next    = 1'b0;
          state_next = CAPTURE;
        end
      end
      CAPTURE: begin
        rsp_tag_next   = cam_tag_out;
        rsp_mode_next  = mode_reg;
        rsp_error_next = 1'b0;
        rsp_valid_next = 1'b1;
        op_count_next  = op_count_reg + 1'b1;
        state_next     = RESP;
      end
      WAIT_WR: begin
        if (cam_write_done) begin
          // Drop chip-enable on the very edge that sees write_done so an
          // update cannot be applied a second time.
          ce_next        = 1'b0;
          rsp_tag_next   = '0;
          rsp_mode_next  = mode_reg;
          rsp_error_next = 1'b0;
          rsp_valid_next = 1'b1;
          op_count_next  = op_count_reg + 1'b1;
          state_next     = RESP;
        end
`ifdef CAM_SEQ_TIMEOUT_EN
        else if (wait_cnt_reg == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
          // Counter value TIMEOUT_CYCLES-1 marks the last allowed WAIT_WR cycle.
          ce_next        = 1'b0;
          rsp_tag_next   = '0;
          rsp_mode_next  = mode_reg;
          rsp_error_next = 1'b1;
          rsp_valid_next = 1'b1;
          state_next     = RESP;
        end else begin
          wait_cnt_next = wait_cnt_reg + 1'b1;
        end
`endif
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      data_reg      <= '0;
      upd_reg       <= 1'b0;
      cmp_addr_reg  <= '0;
      ppg_addr_reg  <= '0;
      cmp_data_reg  <= '0;
      ppg_data_reg  <= '0;
      tag_in_reg    <= '0;
      addr_sel_reg  <= 1'b0;
      mode_reg      <= '0;
      ce_reg        <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_tag_reg   <= '0;
      rsp_mode_reg  <= '0;
      rsp_error_reg <= 1'b0;
      op_count_reg  <= '0;
`ifdef CAM_SEQ_TIMEOUT_EN
      wait_cnt_reg  <= '0;
`endif
    end else begin
      state_reg     <= state_next;
      data_reg      <= data_next;
      upd_reg       <= upd_next;
      cmp_addr_reg  <= cmp_addr_next;
      ppg_addr_reg  <= ppg_addr_next;
      cmp_data_reg  <= cmp_data_next;
      ppg_data_reg  <= ppg_data_next;
      tag_in_reg    <= tag_in_next;
      addr_sel_reg  <= addr_sel_next;
      mode_reg      <= mode_next;
      ce_reg        <= ce_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_tag_reg   <= rsp_tag_next;
      rsp_mode_reg  <= rsp_mode_next;
      rsp_error_reg <= rsp_error_next;
      op_count_reg  <= op_count_next;
`ifdef CAM_SEQ_TIMEOUT_EN
      wait_cnt_reg  <= wait_cnt_next;
`endif
    end
  end

  assign cam_data_in        = data_reg;
  assign cam_update_signal  = upd_reg;
  assign cam_cmp_addr       = cmp_addr_reg;
  assign cam_ppg_addr       = ppg_addr_reg;
  assign cam_cmp_data       = cmp_data_reg;
  assign cam_ppg_data       = ppg_data_reg;
  assign cam_tag_in         = tag_in_reg;
  assign cam_addr_select    = addr_sel_reg;
  assign cam_operation_mode = mode_reg;
  assign cam_chip_enable    = ce_reg;
  assign rsp_valid          = rsp_valid_reg;
  assign rsp_tag            = rsp_tag_reg;
  assign rsp_mode           = rsp_mode_reg;
  assign rsp_error          = rsp_error_reg;
  assign op_count           = op_count_reg;

endmodule

// File: tb/tb_cam_subarray_sequencer.sv
// Directed testbench for cam_subarray_sequencer. A small behavioural
// subarray model answers writes with a write_done pulse one edge after it
// first sees chip-enable, and answers searches with the last written word.
module tb_cam_subarray_sequencer;

  logic        CLK = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_mode = 3'b000;
  logic        cmd_addr_select = 1'b0;
  logic [9:0]  cmd_cmp_addr = '0;
  logic [3:0]  cmd_ppg_addr = '0;
  logic [1:0]  cmd_cmp_data = '0;
  logic [1:0]  cmd_ppg_data = '0;
  logic [15:0] cmd_data = '0;
  logic [15:0] cmd_tag = '0;
  logic        cmd_update = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_tag;
  logic [2:0]  rsp_mode;
  logic        rsp_error;
  logic [15:0] cam_data_in;
  logic        cam_update_signal;
  logic [9:0]  cam_cmp_addr;
  logic [3:0]  cam_ppg_addr;
  logic [1:0]  cam_cmp_data;
  logic [1:0]  cam_ppg_data;
  logic [15:0] cam_tag_in;
  logic        cam_addr_select;
  logic [2:0]  cam_operation_mode;
  logic        cam_chip_enable;
  logic [15:0] cam_tag_out;
  logic        cam_write_done;
  logic        busy;
  logic [15:0] op_count;

  int checks = 0;
  int failures = 0;

  // Subarray model state.
  logic        wd_enable = 1'b1;
  logic [15:0] mem_word;
  int          write_count;
  int          ce_cycles;

  cam_subarray_sequencer #(.TIMEOUT_CYCLES(8), .CNT_W(16)) dut (
    .CLK(CLK), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
    .cmd_addr_select(cmd_addr_select), .cmd_cmp_addr(cmd_cmp_addr),
    .cmd_ppg_addr(cmd_ppg_addr), .cmd_cmp_data(cmd_cmp_data),
    .cmd_ppg_data(cmd_ppg_data), .cmd_data(cmd_data), .cmd_tag(cmd_tag),
    .cmd_update(cmd_update),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tag(rsp_tag),
    .rsp_mode(rsp_mode), .rsp_error(rsp_error),
    .cam_data_in(cam_data_in), .cam_update_signal(cam_update_signal),
    .cam_cmp_addr(cam_cmp_addr), .cam_ppg_addr(cam_ppg_addr),
    .cam_cmp_data(cam_cmp_data), .cam_ppg_data(cam_ppg_data),
    .cam_tag_in(cam_tag_in), .cam_addr_select(cam_addr_select),
    .cam_operation_mode(cam_operation_mode), .cam_chip_enable(cam_chip_enable),
    .cam_tag_out(cam_tag_out), .cam_write_done(cam_write_done),
    .busy(busy), .op_count(op_count)
  );

  always #5 CLK = ~CLK;

  // Subarray model: write_done pulses once per chip-enable episode; a write
  // is counted each time the pulse lands while chip-enable is still high,
  // so a chip-enable held too long shows up as a second write.
  always @(posedge CLK or negedge rst) begin
    if (!rst) begin
      cam_write_done <= 1'b0;
      cam_tag_out    <= '0;
    end else begin
      cam_write_done <= wd_enable && cam_chip_enable &&
                        (cam_operation_mode[2:1] == 2'b00) && !cam_write_done;
      if (cam_chip_enable && cam_operation_mode[2:1] != 2'b00 &&
          cam_operation_mode != 3'b111)
        cam_tag_out <= mem_word;
    end
  end

  always @(posedge CLK) begin
    if (cam_chip_enable) ce_cycles <= ce_cycles + 1;
    if (cam_chip_enable && cam_write_done) begin
      write_count <= write_count + 1;
      mem_word    <= cam_data_in;
    end
  end

  initial begin
    write_count = 0;
    ce_cycles   = 0;
    mem_word    = '0;
  end

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // Presents one command at a negedge and returns at the negedge after the
  // accepting edge (E0) with cmd_valid dropped.
  task automatic issue(input logic [2:0] mode, input logic [9:0] caddr,
                       input logic [1:0] cdata, input logic [15:0] data);
    cmd_mode     = mode;
    cmd_cmp_addr = caddr;
    cmd_cmp_data = cdata;
    cmd_data     = data;
    cmd_valid    = 1'b1;
    tick();
    cmd_valid    = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    cmd_valid = 1'b1;
    cmd_mode = 3'b000;
    tick();
    tick();
    checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL reset_cmd_ready got=%0b exp=0", cmd_ready); end
    checks++; if (cam_chip_enable !== 1'b0) begin failures++; $display("FAIL reset_ce got=%0b exp=0", cam_chip_enable); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%0b exp=0", rsp_valid); end
    checks++; if (op_count !== 16'd0) begin failures++; $display("FAIL reset_op_count got=%0d exp=0", op_count); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    cmd_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_release_cmd_ready got=%0b exp=1", cmd_ready); end
    tick();
    $display("test_reset done");
  endtask

  task automatic test_write();
    int w0, c0;
    w0 = write_count;
    c0 = ce_cycles;
    issue(3'b000, 10'd5, 2'b00, 16'hA5A5);
    checks++; if (cam_chip_enable !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL write_e0_ce_busy got=%0b%0b exp=11", cam_chip_enable, busy); end
    checks++; if (cam_data_in !== 16'hA5A5 || cam_cmp_addr !== 10'd5) begin failures++; $display("FAIL write_operands got=%h/%0d exp=a5a5/5", cam_data_in, cam_cmp_addr); end
    tick();
    checks++; if (rsp_valid !== 1'b0 || cam_chip_enable !== 1'b1) begin failures++; $display("FAIL write_e1 rsp_valid/ce got=%0b%0b exp=01", rsp_valid, cam_chip_enable); end
    tick();
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL write_rsp_valid got=%0b exp=1", rsp_valid); end
    checks++; if (cam_chip_enable !== 1'b0) begin failures++; $display("FAIL write_ce_drop got=%0b exp=0", cam_chip_enable); end
    checks++; if (rsp_tag !== 16'h0 || rsp_error !== 1'b0 || rsp_mode !== 3'b000) begin failures++; $display("FAIL write_rsp got tag=%h err=%0b mode=%b exp tag=0000 err=0 mode=000", rsp_tag, rsp_error, rsp_mode); end
    checks++; if (op_count !== 16'd1) begin failures++; $display("FAIL write_op_count got=%0d exp=1", op_count); end
    checks++; if (ce_cycles - c0 !== 2) begin failures++; $display("FAIL write_ce_cycles got=%0d exp=2", ce_cycles - c0); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++; if (write_count - w0 !== 1) begin failures++; $display("FAIL write_count got=%0d exp=1", write_count - w0); end
    checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin failures++; $display("FAIL write_handshake rsp_valid/cmd_ready got=%0b%0b exp=01", rsp_valid, cmd_ready); end
    $display("test_write mode=000 addr=5 data=a5a5 tag=%h op_count=%0d", rsp_tag, op_count);
  endtask

  task automatic test_search();
    int w0, c0;
    w0 = write_count;
    c0 = ce_cycles;
    issue(3'b010, 10'd5, 2'b01, 16'h0000);
    checks++; if (cam_cmp_data !== 2'b01 || cam_operation_mode !== 3'b010) begin failures++; $display("FAIL search_operands got=%b/%b exp=01/010", cam_cmp_data, cam_operation_mode); end
    tick();
    checks++; if (cam_chip_enable !== 1'b0 || rsp_valid !== 1'b0) begin failures++; $display("FAIL search_e1 ce/rsp_valid got=%0b%0b exp=00", cam_chip_enable, rsp_valid); end
    tick();
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL search_rsp_valid got=%0b exp=1", rsp_valid); end
    checks++; if (rsp_tag !== 16'hA5A5) begin failures++; $display("FAIL search_rsp_tag got=%h exp=a5a5", rsp_tag); end
    checks++; if (rsp_mode !== 3'b010 || rsp_error !== 1'b0) begin failures++; $display("FAIL search_mode_err got=%b/%0b exp=010/0", rsp_mode, rsp_error); end
    checks++; if (op_count !== 16'd2) begin failures++; $display("FAIL search_op_count got=%0d exp=2", op_count); end
    checks++; if (ce_cycles - c0 !== 1 || write_count != w0) begin failures++; $display("FAIL search_ce_writes got ce=%0d wr=%0d exp ce=1 wr=0", ce_cycles - c0, write_count - w0); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    $display("test_search mode=010 addr=5 tag=%h op_count=%0d", rsp_tag, op_count);
  endtask

  task automatic test_back_to_back();
    int w0;
    issue(3'b011, 10'd5, 2'b10, 16'hBEEF);
    tick();
    tick();
    // Second command waits while the response is stalled.
    cmd_mode  = 3'b000;
    cmd_data  = 16'h1234;
    cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (rsp_valid !== 1'b1 || rsp_tag !== 16'hA5A5 || rsp_mode !== 3'b011) begin failures++; $display("FAIL stall_hold[%0d] got v=%0b tag=%h mode=%b exp v=1 tag=a5a5 mode=011", i, rsp_valid, rsp_tag, rsp_mode); end
      checks++; if (cmd_ready !== 1'b0 || cam_operation_mode !== 3'b011) begin failures++; $display("FAIL stall_no_accept[%0d] got ready=%0b mode=%b exp ready=0 mode=011", i, cmd_ready, cam_operation_mode); end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin failures++; $display("FAIL b2b_idle got v=%0b busy=%0b ready=%0b exp 0/0/1", rsp_valid, busy, cmd_ready); end
    w0 = write_count;
    tick();
    cmd_valid = 1'b0;
    checks++; if (busy !== 1'b1 || cam_data_in !== 16'h1234 || cam_operation_mode !== 3'b000) begin failures++; $display("FAIL b2b_accept got busy=%0b data=%h mode=%b exp 1/1234/000", busy, cam_data_in, cam_operation_mode); end
    tick();
    tick();
    checks++; if (rsp_valid !== 1'b1 || op_count !== 16'd4) begin failures++; $display("FAIL b2b_write_rsp got v=%0b cnt=%0d exp 1/4", rsp_valid, op_count); end
    tick();
    rsp_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b0 || write_count - w0 !== 1) begin failures++; $display("FAIL b2b_done got v=%0b writes=%0d exp 0/1", rsp_valid, write_count - w0); end
    $display("test_back_to_back search tag=a5a5 then write data=1234 op_count=%0d", op_count);
  endtask

  task automatic test_illegal();
    int c0;
    c0 = ce_cycles;
    issue(3'b111, 10'd3, 2'b11, 16'hFFFF);
    checks++; if (rsp_valid !== 1'b1 || rsp_error !== 1'b1 || rsp_tag !== 16'h0) begin failures++; $display("FAIL illegal_rsp got v=%0b err=%0b tag=%h exp 1/1/0000", rsp_valid, rsp_error, rsp_tag); end
    checks++; if (cam_chip_enable !== 1'b0 || cam_operation_mode !== 3'b000) begin failures++; $display("FAIL illegal_no_cam got ce=%0b mode=%b exp 0/000", cam_chip_enable, cam_operation_mode); end
    checks++; if (op_count !== 16'd4) begin failures++; $display("FAIL illegal_op_count got=%0d exp=4", op_count); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++; if (ce_cycles != c0 || cmd_ready !== 1'b1) begin failures++; $display("FAIL illegal_ce_pulse got ce=%0d ready=%0b exp 0/1", ce_cycles - c0, cmd_ready); end
    $display("test_illegal mode=111 err=%0b op_count=%0d", rsp_error, op_count);
  endtask

  task automatic test_midop_reset();
    wd_enable = 1'b0;
    issue(3'b001, 10'd7, 2'b00, 16'h5555);
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++; if (cam_chip_enable !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b0) begin failures++; $display("FAIL midreset_async got ce=%0b busy=%0b ready=%0b exp 0/0/0", cam_chip_enable, busy, cmd_ready); end
    checks++; if (rsp_valid !== 1'b0 || rsp_error !== 1'b0 || op_count !== 16'd0 || cam_data_in !== 16'h0) begin failures++; $display("FAIL midreset_outputs got v=%0b err=%0b cnt=%0d data=%h exp 0/0/0/0000", rsp_valid, rsp_error, op_count, cam_data_in); end
    tick();
    rst = 1'b1;
    wd_enable = 1'b1;
    tick();
    checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin failures++; $display("FAIL midreset_no_rsp got v=%0b ready=%0b exp 0/1", rsp_valid, cmd_ready); end
    $display("test_midop_reset mode=001 dropped op_count=%0d", op_count);
  endtask

  task automatic test_timeout();
    wd_enable = 1'b0;
    issue(3'b000, 10'd9, 2'b00, 16'h0F0F);
`ifdef CAM_SEQ_TIMEOUT_EN
    for (int i = 1; i <= 8; i++) begin
      tick();
      checks++; if (cam_chip_enable !== 1'b1 || rsp_valid !== 1'b0) begin failures++; $display("FAIL timeout_wait[%0d] got ce=%0b v=%0b exp 1/0", i, cam_chip_enable, rsp_valid); end
    end
    tick();
    checks++; if (cam_chip_enable !== 1'b0 || rsp_valid !== 1'b1 || rsp_error !== 1'b1) begin failures++; $display("FAIL timeout_abort got ce=%0b v=%0b err=%0b exp 0/1/1", cam_chip_enable, rsp_valid, rsp_error); end
    checks++; if (op_count !== 16'd0 || rsp_tag !== 16'h0) begin failures++; $display("FAIL timeout_count got cnt=%0d tag=%h exp 0/0000", op_count, rsp_tag); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
`else
    for (int i = 0; i < 30; i++) tick();
    checks++; if (busy !== 1'b1 || cam_chip_enable !== 1'b1 || rsp_valid !== 1'b0) begin failures++; $display("FAIL notimeout_wait got busy=%0b ce=%0b v=%0b exp 1/1/0", busy, cam_chip_enable, rsp_valid); end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
`endif
    wd_enable = 1'b1;
    $display("test_timeout busy=%0b op_count=%0d", busy, op_count);
  endtask

  initial begin
    test_reset();
    test_write();
    test_search();
    test_back_to_back();
    test_illegal();
    test_midop_reset();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
